backend_cfg_sequencer: RTL and testbench

// - Configures and brings up the analog backend from a parallel request. Resets the backend,

---
 rtl/backend_cfg_pkg.sv | 10 +
 rtl/backend_cfg_serializer.sv | 66 ++++++
 rtl/backend_cfg_sequencer.sv | 119 +++++++++++
 tb/tb_backend_cfg_sequencer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/backend_cfg_pkg.sv
// backend_cfg_pkg: shared state encoding and frame width for the backend config sequencer
package backend_cfg_pkg;
  localparam int CFG_FRAME_W = 5;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RST   = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;
endpackage

// File: rtl/backend_cfg_serializer.sv
// backend_cfg_serializer: shifts a gain frame MSB first as sdin bits, each closed by a 1-cycle sclk strobe
module backend_cfg_serializer import backend_cfg_pkg::*; #(
  parameter int SCLK_GAP = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [CFG_FRAME_W-1:0] frame_i,
  output logic                   sclk_o,
  output logic                   sdin_o,
  output logic                   done_o
);
  localparam int PW = $clog2(SCLK_GAP + 1);
  localparam int BW = $clog2(CFG_FRAME_W);
  localparam logic [PW-1:0] PH_LAST = PW'(SCLK_GAP);
  logic [CFG_FRAME_W-1:0] sr_q, sr_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [BW-1:0] bit_q, bit_d;
  logic act_q, act_d, sclk_q, sclk_d, sdin_q, sdin_d, last;
  assign last   = act_q && ph_q == PH_LAST;
  assign done_o = last && bit_q == '0;
  assign sclk_o = sclk_q;
  assign sdin_o = sdin_q;
  always_comb begin
    sr_d   = sr_q;
    ph_d   = ph_q;
    bit_d  = bit_q;
    act_d  = act_q;
    sclk_d = 1'b0;
    sdin_d = sdin_q;
    if (start_i) begin
      sr_d   = frame_i;
      sdin_d = frame_i[CFG_FRAME_W-1];
      ph_d   = '0;
      bit_d  = BW'(CFG_FRAME_W - 1);
      act_d  = 1'b1;
    end else if (last) begin
      // the strobe cycle of a bit ends it; the next bit (or idle 0) starts right away
      act_d  = bit_q != '0;
      sr_d   = sr_q << 1;
      sdin_d = bit_q != '0 && sr_q[CFG_FRAME_W-2];
      ph_d   = '0;
      bit_d  = bit_q - BW'(bit_q != '0);
    end else if (act_q) begin
      ph_d   = ph_q + PW'(1);
      sclk_d = ph_d == PH_LAST;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q   <= '0;
      ph_q   <= '0;
      bit_q  <= '0;
      act_q  <= 1'b0;
      sclk_q <= 1'b0;
      sdin_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      ph_q   <= ph_d;
      bit_q  <= bit_d;
      act_q  <= act_d;
      sclk_q <= sclk_d;
      sdin_q <= sdin_d;
    end
  end
endmodule

// File: rtl/backend_cfg_sequencer.sv
// backend_cfg_sequencer: resets the analog backend, sends the gain frame, waits for ready with retries
module backend_cfg_sequencer import backend_cfg_pkg::*; #(
  parameter int RST_CYCLES     = 16,
  parameter int SCLK_GAP       = 3,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int MAX_RETRY      = 2
) (
  input  logic       i_clk,
  input  logic       i_resetbAll,
  input  logic       i_cfg_valid,
  output logic       o_cfg_ready,
  input  logic [2:0] i_cfg_gainA1,
  input  logic [1:0] i_cfg_gainA2,
  output logic       o_resetb_backend,
  output logic       o_sclk,
  output logic       o_sdin,
  input  logic       i_backend_ready,
  input  logic       i_vco1_fast,
  output logic       o_vco1_fast,
  output logic       o_done,
  output logic       o_timeout,
  output logic       o_busy
);
  localparam int CNT_MAX = RST_CYCLES > TIMEOUT_CYCLES ? RST_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  logic [2:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [CFG_FRAME_W-1:0] frame_q, frame_d;
  logic resetb_q, resetb_d, rdy_q, rdy_d, vco_q, vco_d, done_q, done_d, to_q, to_d, busy_q, busy_d;
  logic ser_start, ser_done, accept;
  assign accept           = i_cfg_valid && rdy_q;
  assign o_cfg_ready      = rdy_q;
  assign o_resetb_backend = resetb_q;
  assign o_vco1_fast      = vco_q;
  assign o_done           = done_q;
  assign o_timeout        = to_q;
  assign o_busy           = busy_q;
  backend_cfg_serializer #(.SCLK_GAP(SCLK_GAP)) u_ser (
    .clk_i  (i_clk),
    .rst_ni (i_resetbAll),
    .start_i(ser_start),
    .frame_i(frame_q),
    .sclk_o (o_sclk),
    .sdin_o (o_sdin),
    .done_o (ser_done)
  );
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(cnt_q != CNT_SAT);
    retry_d   = retry_q;
    frame_d   = frame_q;
    vco_d     = vco_q;
    to_d      = to_q;
    ser_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERROR: if (accept) begin
        state_d = ST_RST;
        cnt_d   = '0;
        frame_d = {i_cfg_gainA2, i_cfg_gainA1};
        to_d    = 1'b0;
        retry_d = '0;
      end
      ST_RST: if (cnt_q == RST_LAST) begin
        state_d   = ST_SHIFT;
        ser_start = 1'b1;
      end
      ST_SHIFT: if (ser_done) begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: if (i_backend_ready) begin
        state_d = ST_DONE;
        vco_d   = i_vco1_fast;
      end else if (cnt_q == TO_LAST) begin
        cnt_d   = '0;
        state_d = retry_q < RETRY_MAX ? ST_RST : ST_ERROR;
        retry_d = retry_q < RETRY_MAX ? retry_q + RW'(1) : retry_q;
        to_d    = retry_q >= RETRY_MAX;
      end
      default: state_d = ST_IDLE;
    endcase
    // backend reset is released when the frame starts and held through idle until the next attempt
    resetb_d = (state_d == ST_RST || state_d == ST_ERROR) ? 1'b0 : (state_d == ST_SHIFT ? 1'b1 : resetb_q);
    rdy_d    = state_d == ST_IDLE || state_d == ST_ERROR;
    busy_d   = !rdy_d;
    done_d   = state_d == ST_DONE;
  end
  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      retry_q  <= '0;
      frame_q  <= '0;
      resetb_q <= 1'b0;
      rdy_q    <= 1'b1;
      vco_q    <= 1'b0;
      done_q   <= 1'b0;
      to_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      frame_q  <= frame_d;
      resetb_q <= resetb_d;
      rdy_q    <= rdy_d;
      vco_q    <= vco_d;
      done_q   <= done_d;
      to_q     <= to_d;
      busy_q   <= busy_d;
    end
  end
endmodule

// File: tb/tb_backend_cfg_sequencer.sv
// tb_backend_cfg_sequencer: table-driven and randomized checks against a cycle-schedule model
module tb_backend_cfg_sequencer;
  localparam int RC  = 16;
  localparam int GAP = 3;
  localparam int TO  = 200;
  localparam int MR  = 2;
  localparam int SH  = 5 * (GAP + 1);
  localparam int ATT = RC + SH + TO;
  logic clk = 1'b0, rstn = 1'b0, valid = 1'b0, bready = 1'b0, vin = 1'b0;
  logic [2:0] a1 = '0;
  logic [1:0] a2 = '0;
  logic o_cfg_ready, o_resetb_backend, o_sclk, o_sdin, o_vco1_fast, o_done, o_timeout, o_busy;
  int n_cmp = 0, n_bad = 0;
  logic prev_vco = 1'b0, idle_rb = 1'b0, idle_to = 1'b0;
  typedef struct {
    logic [2:0] a1; logic [1:0] a2; int s; int d; logic vv; bit hold; bit noise;
    logic [4:0] bits; int sclks; int rises;
  } vec_t;
  vec_t tbl[6];
  int nsc, nri;
  logic [4:0] b0;

  backend_cfg_sequencer #(.RST_CYCLES(RC), .SCLK_GAP(GAP), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
    .i_clk(clk), .i_resetbAll(rstn), .i_cfg_valid(valid), .o_cfg_ready(o_cfg_ready),
    .i_cfg_gainA1(a1), .i_cfg_gainA2(a2), .o_resetb_backend(o_resetb_backend),
    .o_sclk(o_sclk), .o_sdin(o_sdin), .i_backend_ready(bready), .i_vco1_fast(vin),
    .o_vco1_fast(o_vco1_fast), .o_done(o_done), .o_timeout(o_timeout), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // {resetb, sclk, sdin, done, timeout, busy, ready, vco}
  function automatic logic [31:0] outv();
    return {24'd0, o_resetb_backend, o_sclk, o_sdin, o_done, o_timeout, o_busy, o_cfg_ready, o_vco1_fast};
  endfunction

  // expected outputs r cycles after the accepting edge, from the attempt schedule alone
  function automatic logic [31:0] model(int r, int s, int d, logic [4:0] fr, logic vv, logic pv);
    int u = r % ATT;
    int j = u - RC;
    int dn = s * ATT + RC + SH + d + 1;
    if (s >= 0 && r == dn) return {24'd0, 7'b1001010, vv};
    if (s >= 0 && r > dn) return {24'd0, 7'b1000001, vv};
    if (s < 0 && r >= (MR + 1) * ATT) return {24'd0, 7'b0000101, pv};
    if (u < RC) return {24'd0, 7'b0000010, pv};
    if (u < RC + SH) return {24'd0, 1'b1, 1'(j % (GAP + 1) == GAP), fr[4 - j / (GAP + 1)], 4'b0010, pv};
    return {24'd0, 7'b1000010, pv};
  endfunction

  task automatic run_txn(input string nm, input logic [2:0] ga1, input logic [1:0] ga2, input int s,
                         input int d, input logic vv, input bit hold, input bit noise, input int abort,
                         output int nsclk, output int nrise, output logic [4:0] bits0);
    logic [4:0] fr;
    logic prb, hit, in_wait;
    int len;
    fr = {ga2, ga1};
    len = s >= 0 ? s * ATT + RC + SH + d + 3 : (MR + 1) * ATT + 1;
    nsclk = 0; nrise = 0; bits0 = '0; prb = idle_rb;
    check({nm, " idle"}, outv(), {24'd0, idle_rb, 3'b000, idle_to, 2'b01, prev_vco});
    a1 = ga1; a2 = ga2; valid = 1'b1;
    @(posedge clk); #1;
    valid = hold;
    a1 = 3'($urandom); a2 = 2'($urandom);
    for (int r = 0; r < len; r++) begin
      check(nm, outv(), model(r, s, d, fr, vv, prev_vco));
      if (o_sclk) begin
        if (nsclk < 5) bits0[4 - nsclk] = o_sdin;
        nsclk++;
      end
      if (o_resetb_backend && !prb) nrise++;
      prb = o_resetb_backend;
      if (r == abort) begin
        #2 rstn = 1'b0;
        #1 check({nm, " async reset"}, outv(), 32'b00000010);
        prev_vco = 1'b0; idle_rb = 1'b0; idle_to = 1'b0;
        valid = 1'b0; bready = 1'b0;
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        return;
      end
      hit = s >= 0 && r == s * ATT + RC + SH + d;
      in_wait = r < (MR + 1) * ATT && (r % ATT) >= RC + SH && !(s >= 0 && r > s * ATT + RC + SH + d);
      bready = hit ? 1'b1 : in_wait ? 1'b0 : noise ? 1'($urandom_range(0, 1)) : 1'b0;
      vin = hit ? vv : 1'($urandom_range(0, 1));
      if (r == len - 1) valid = 1'b0;
      @(posedge clk); #1;
    end
    if (s >= 0) begin
      prev_vco = vv; idle_rb = 1'b1; idle_to = 1'b0;
    end else begin
      idle_rb = 1'b0; idle_to = 1'b1;
    end
  endtask

  initial begin
    int s, pick, att;
    logic [2:0] r1;
    logic [1:0] r2;
    tbl[0] = '{3'b101, 2'b10,  0,  10, 1'b1, 1'b0, 1'b0, 5'b10101,  5, 1};
    tbl[1] = '{3'b101, 2'b10,  0,   3, 1'b0, 1'b0, 1'b0, 5'b10101,  5, 1};
    tbl[2] = '{3'b000, 2'b00, -1,   0, 1'b1, 1'b0, 1'b1, 5'b00000, 15, 3};
    tbl[3] = '{3'b111, 2'b11,  0, 199, 1'b1, 1'b1, 1'b1, 5'b11111,  5, 1};
    tbl[4] = '{3'b010, 2'b01,  1,   0, 1'b0, 1'b0, 1'b1, 5'b01010, 10, 2};
    tbl[5] = '{3'b001, 2'b11,  2, 199, 1'b1, 1'b1, 1'b0, 5'b11001, 15, 3};
    repeat (3) @(posedge clk);
    #1 check("reset", outv(), 32'b00000010);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      run_txn($sformatf("tbl%0d", i), tbl[i].a1, tbl[i].a2, tbl[i].s, tbl[i].d, tbl[i].vv,
              tbl[i].hold, tbl[i].noise, -1, nsc, nri, b0);
      check($sformatf("tbl%0d bits", i), 32'(b0), 32'(tbl[i].bits));
      check($sformatf("tbl%0d sclks", i), nsc, tbl[i].sclks);
      check($sformatf("tbl%0d rst pulses", i), nri, tbl[i].rises);
    end
    run_txn("abort", 3'b110, 2'b01, 0, 5, 1'b1, 1'b0, 1'b0, RC + 2 * (GAP + 1) + 1, nsc, nri, b0);
    run_txn("post_abort", 3'b110, 2'b01, 0, 20, 1'b1, 1'b0, 1'b0, -1, nsc, nri, b0);
    check("post_abort bits", 32'(b0), 32'(5'b01110));
    check("post_abort sclks", nsc, 5);
    for (int i = 0; i < 14; i++) begin
      r1 = 3'($urandom); r2 = 2'($urandom);
      pick = $urandom_range(0, 9);
      s = pick <= 6 ? 0 : pick == 7 ? 1 : pick == 8 ? 2 : -1;
      att = s >= 0 ? s + 1 : MR + 1;
      run_txn($sformatf("rnd%0d", i), r1, r2, s, $urandom_range(0, TO - 1), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, nsc, nri, b0);
      check($sformatf("rnd%0d bits", i), 32'(b0), 32'({r2, r1}));
      check($sformatf("rnd%0d sclks", i), nsc, 5 * att);
      check($sformatf("rnd%0d rst pulses", i), nri, att);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
